// File: rtl/ex_hazard_core.sv
// Execute stage of the 5-stage RV32I pipeline: forwarding, ALU, branch/jump targets, hazard unit
// and the EX->MEM register. Optional hazard counters are built when HAZARD_PERF_EN is defined.
module ex_hazard_core #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rd1E,
  input  logic [31:0]      rd2E,
  input  logic [31:0]      pcE,
  input  logic [31:0]      immE,
  input  logic [3:0]       alucontrolE,
  input  logic             alusrcAE,
  input  logic [1:0]       alusrcBE,
  input  logic             jumpsrcE,
  input  logic             jumpE,
  input  logic             branchE,
  input  logic             inv_brE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             memwriteE,
  input  logic [4:0]       ra1E,
  input  logic [4:0]       ra2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       ra1D,
  input  logic [4:0]       ra2D,
  input  logic [31:0]      resultW,
  input  logic [4:0]       rdW,
  input  logic             regwriteW,
  output logic             pcsrcE,
  output logic [31:0]      pcbranchE,
  output logic [31:0]      jmp_fin_pcE,
  output logic             controlChange,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [31:0]      aluoutM,
  output logic [31:0]      writedataM,
  output logic [4:0]       rdM,
  output logic             regwriteM,
  output logic             memtoregM,
  output logic             memwriteM,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] fwdA, fwdB;
  logic [31:0] srcA, srcB;
  logic [31:0] aluResult;
  logic [31:0] jumpBase;
  logic [31:0] jumpSum;
  logic [4:0]  shamt;
  logic        isZero;
  logic        lwStall;

  // M-stage match wins over W-stage: it holds the younger result.
  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (ra1E == rdM)) begin
      forwardAE = 2'b10;
    end else if (regwriteW && (rdW != 5'd0) && (ra1E == rdW)) begin
      forwardAE = 2'b01;
    end
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (ra2E == rdM)) begin
      forwardBE = 2'b10;
    end else if (regwriteW && (rdW != 5'd0) && (ra2E == rdW)) begin
      forwardBE = 2'b01;
    end
  end

  always_comb begin
    fwdA = rd1E;
    if (forwardAE[1]) begin
      fwdA = aluoutM;
    end else if (forwardAE[0]) begin
      fwdA = resultW;
    end
  end

  always_comb begin
    fwdB = rd2E;
    if (forwardBE[1]) begin
      fwdB = aluoutM;
    end else if (forwardBE[0]) begin
      fwdB = resultW;
    end
  end

  assign srcA = alusrcAE ? pcE : fwdA;

  always_comb begin
    srcB = fwdB;
    if (alusrcBE == 2'b01) begin
      srcB = immE;
    end else if (alusrcBE[1]) begin
      srcB = 32'd4;
    end
  end

  assign shamt = srcB[4:0];

  always_comb begin
    aluResult = 32'd0;
    case (alucontrolE)
      4'b0000: aluResult = srcA + srcB;
      4'b1000: aluResult = srcA - srcB;
      4'b0001: aluResult = srcA << shamt;
      4'b0010: aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
      4'b0011: aluResult = {31'd0, srcA < srcB};
      4'b0100: aluResult = srcA ^ srcB;
      4'b0101: aluResult = srcA >> shamt;
      4'b1101: aluResult = $unsigned($signed(srcA) >>> shamt);
      4'b0110: aluResult = srcA | srcB;
      4'b0111: aluResult = srcA & srcB;
      4'b1001: aluResult = srcB;
      default: aluResult = 32'd0;
    endcase
  end

  assign isZero = (aluResult == 32'd0);

  assign pcsrcE    = branchE & (isZero ^ inv_brE);
  assign pcbranchE = pcE + immE;

  // JALR base is the raw register read; the LSB is cleared per the ISA.
  assign jumpBase    = jumpsrcE ? rd1E : pcE;
  assign jumpSum     = jumpBase + immE;
  assign jmp_fin_pcE = {jumpSum[31:1], 1'b0};

  assign controlChange = pcsrcE | jumpE;

  assign lwStall = memtoregE && (rdE != 5'd0) && ((rdE == ra1D) || (rdE == ra2D));
  assign stallF  = lwStall;
  assign stallD  = lwStall;
  // A taken redirect squashes D, so the load-use stall of D is moot in that case.
  assign flushD  = controlChange;
  assign flushE  = lwStall | controlChange;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluoutM    <= 32'd0;
      writedataM <= 32'd0;
      rdM        <= 5'd0;
      regwriteM  <= 1'b0;
      memtoregM  <= 1'b0;
      memwriteM  <= 1'b0;
    end else begin
      aluoutM    <= aluResult;
      writedataM <= fwdB;
      rdM        <= rdE;
      regwriteM  <= regwriteE;
      memtoregM  <= memtoregE;
      memwriteM  <= memwriteE;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (lwStall) begin
        stallCntQ <= stallCntQ + 1'b1;
      end
      if (controlChange) begin
        flushCntQ <= flushCntQ + 1'b1;
      end
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_core.sv
// Directed self-checking bench for ex_hazard_core; counter checks follow HAZARD_PERF_EN.
module tb_ex_hazard_core;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      rd1E, rd2E, pcE, immE;
  logic [3:0]       alucontrolE;
  logic             alusrcAE;
  logic [1:0]       alusrcBE;
  logic             jumpsrcE, jumpE, branchE, inv_brE;
  logic             regwriteE, memtoregE, memwriteE;
  logic [4:0]       ra1E, ra2E, rdE, ra1D, ra2D;
  logic [31:0]      resultW;
  logic [4:0]       rdW;
  logic             regwriteW;
  logic             pcsrcE;
  logic [31:0]      pcbranchE, jmp_fin_pcE;
  logic             controlChange, stallF, stallD, flushD, flushE;
  logic [1:0]       forwardAE, forwardBE;
  logic [31:0]      aluoutM, writedataM;
  logic [4:0]       rdM;
  logic             regwriteM, memtoregM, memwriteM;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_hazard_core #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd1E         (rd1E),
    .rd2E         (rd2E),
    .pcE          (pcE),
    .immE         (immE),
    .alucontrolE  (alucontrolE),
    .alusrcAE     (alusrcAE),
    .alusrcBE     (alusrcBE),
    .jumpsrcE     (jumpsrcE),
    .jumpE        (jumpE),
    .branchE      (branchE),
    .inv_brE      (inv_brE),
    .regwriteE    (regwriteE),
    .memtoregE    (memtoregE),
    .memwriteE    (memwriteE),
    .ra1E         (ra1E),
    .ra2E         (ra2E),
    .rdE          (rdE),
    .ra1D         (ra1D),
    .ra2D         (ra2D),
    .resultW      (resultW),
    .rdW          (rdW),
    .regwriteW    (regwriteW),
    .pcsrcE       (pcsrcE),
    .pcbranchE    (pcbranchE),
    .jmp_fin_pcE  (jmp_fin_pcE),
    .controlChange(controlChange),
    .stallF       (stallF),
    .stallD       (stallD),
    .flushD       (flushD),
    .flushE       (flushE),
    .forwardAE    (forwardAE),
    .forwardBE    (forwardBE),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .rdM          (rdM),
    .regwriteM    (regwriteM),
    .memtoregM    (memtoregM),
    .memwriteM    (memwriteM),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ALU sweep with a=0x80000000, b=1
  logic [3:0]  aluCodes [12] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                 4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001, 4'b1010};
  logic [31:0] aluExp   [12] = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                                 32'h0000_0000, 32'h8000_0001, 32'h4000_0000, 32'hC000_0000,
                                 32'h8000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};

  task automatic clear_inputs();
    rd1E = '0; rd2E = '0; pcE = '0; immE = '0;
    alucontrolE = '0; alusrcAE = 1'b0; alusrcBE = 2'b00;
    jumpsrcE = 1'b0; jumpE = 1'b0; branchE = 1'b0; inv_brE = 1'b0;
    regwriteE = 1'b0; memtoregE = 1'b0; memwriteE = 1'b0;
    ra1E = '0; ra2E = '0; rdE = '0; ra1D = '0; ra2D = '0;
    resultW = '0; rdW = '0; regwriteW = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #2;
    total++;
    if ({aluoutM, writedataM, rdM, regwriteM, memtoregM, memwriteM} !== '0) begin
      bad++;
      $display("FAIL reset_regs: got %h/%h/%h/%b%b%b want all zero", aluoutM, writedataM, rdM,
               regwriteM, memtoregM, memwriteM);
    end
    total++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    // Clock edges while held in reset must not capture anything.
    rd1E = 32'h55; alusrcBE = 2'b01; immE = 32'h1; rdE = 5'd7; regwriteE = 1'b1;
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'd0 || rdM !== 5'd0 || regwriteM !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got aluoutM=%h rdM=%0d regwriteM=%b want 0/0/0", aluoutM, rdM,
               regwriteM);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      rd1E = 32'h8000_0000; rd2E = 32'h1; alucontrolE = aluCodes[i]; branchE = 1'b1;
      #1;
      total++;
      if (pcsrcE !== (aluExp[i] == 32'd0)) begin
        bad++;
        $display("FAIL alu_iszero[%b]: got pcsrcE=%b want %b", aluCodes[i], pcsrcE,
                 aluExp[i] == 32'd0);
      end
      @(posedge clk); #1;
      total++;
      if (aluoutM !== aluExp[i]) begin
        bad++;
        $display("FAIL alu[%b]: got %h want %h", aluCodes[i], aluoutM, aluExp[i]);
      end
    end
    // Shift amount uses only b[4:0]; srcB=4 via select 10.
    clear_inputs();
    rd1E = 32'h0000_00F0; rd2E = 32'h24; alucontrolE = 4'b0001;
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'h0000_0F00) begin
      bad++;
      $display("FAIL alu_shamt: got %h want 00000f00", aluoutM);
    end
    clear_inputs();
    pcE = 32'h400; alusrcAE = 1'b1; alusrcBE = 2'b10;
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'h404) begin
      bad++;
      $display("FAIL alu_pc_plus4: got %h want 00000404", aluoutM);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    rd1E = 32'd7; alusrcBE = 2'b01; rdE = 5'd5; regwriteE = 1'b1;
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'd7 || rdM !== 5'd5 || regwriteM !== 1'b1) begin
      bad++;
      $display("FAIL fwd_setup: got aluoutM=%h rdM=%0d regwriteM=%b want 7/5/1", aluoutM, rdM,
               regwriteM);
    end
    clear_inputs();
    regwriteW = 1'b1; rdW = 5'd5; resultW = 32'd9;
    ra1E = 5'd5; ra2E = 5'd5; rd1E = 32'h111; rd2E = 32'h222; alusrcBE = 2'b01;
    #1;
    total++;
    if (forwardAE !== 2'b10 || forwardBE !== 2'b10) begin
      bad++;
      $display("FAIL fwd_prio: got %b/%b want 10/10", forwardAE, forwardBE);
    end
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'd7 || writedataM !== 32'd7) begin
      bad++;
      $display("FAIL fwd_m_data: got %h/%h want 7/7", aluoutM, writedataM);
    end
    // regwriteM is now 0, so W supplies the operands.
    total++;
    if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin
      bad++;
      $display("FAIL fwd_w_sel: got %b/%b want 01/01", forwardAE, forwardBE);
    end
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'd9 || writedataM !== 32'd9) begin
      bad++;
      $display("FAIL fwd_w_data: got %h/%h want 9/9", aluoutM, writedataM);
    end
    ra1E = 5'd0; #1;
    total++;
    if (forwardAE !== 2'b00) begin
      bad++;
      $display("FAIL fwd_x0: got %b want 00", forwardAE);
    end
    ra1E = 5'd5; rdW = 5'd0; #1;
    total++;
    if (forwardAE !== 2'b00) begin
      bad++;
      $display("FAIL fwd_rdw0: got %b want 00", forwardAE);
    end
  endtask

  task automatic test_loaduse();
    clear_inputs();
    memtoregE = 1'b1; rdE = 5'd3; ra2D = 5'd3;
    #1;
    total++;
    if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
      bad++;
      $display("FAIL lwstall_ra2: got %b want 1110", {stallF, stallD, flushE, flushD});
    end
    ra2D = 5'd0; ra1D = 5'd3; #1;
    total++;
    if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
      bad++;
      $display("FAIL lwstall_ra1: got %b want 1110", {stallF, stallD, flushE, flushD});
    end
    rdE = 5'd0; ra1D = 5'd0; ra2D = 5'd0; #1;
    total++;
    if ({stallF, stallD, flushE, flushD} !== 4'b0000) begin
      bad++;
      $display("FAIL lwstall_x0: got %b want 0000", {stallF, stallD, flushE, flushD});
    end
    rdE = 5'd3; ra1D = 5'd3; memtoregE = 1'b0; #1;
    total++;
    if ({stallF, stallD, flushE, flushD} !== 4'b0000) begin
      bad++;
      $display("FAIL lwstall_noload: got %b want 0000", {stallF, stallD, flushE, flushD});
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branchE = 1'b1; inv_brE = 1'b1; alucontrolE = 4'b1000; rd1E = 32'd5; rd2E = 32'd3;
    pcE = 32'h0000_0100; immE = 32'h0000_0020;
    #1;
    total++;
    if ({pcsrcE, controlChange, flushD, flushE} !== 4'b1111) begin
      bad++;
      $display("FAIL br_taken: got %b want 1111", {pcsrcE, controlChange, flushD, flushE});
    end
    total++;
    if (pcbranchE !== 32'h0000_0120) begin
      bad++;
      $display("FAIL br_target: got %h want 00000120", pcbranchE);
    end
    inv_brE = 1'b0; #1;
    total++;
    if ({pcsrcE, controlChange, flushD, flushE} !== 4'b0000) begin
      bad++;
      $display("FAIL br_not_taken: got %b want 0000", {pcsrcE, controlChange, flushD, flushE});
    end
    pcE = 32'hFFFF_FFF0; immE = 32'h0000_0020; #1;
    total++;
    if (pcbranchE !== 32'h0000_0010) begin
      bad++;
      $display("FAIL br_wrap: got %h want 00000010", pcbranchE);
    end
  endtask

  task automatic test_jump();
    clear_inputs();
    jumpE = 1'b1; jumpsrcE = 1'b1; rd1E = 32'h1001; immE = 32'd2; pcE = 32'h8000;
    #1;
    total++;
    if (jmp_fin_pcE !== 32'h1002 || controlChange !== 1'b1) begin
      bad++;
      $display("FAIL jalr: got %h cc=%b want 00001002 cc=1", jmp_fin_pcE, controlChange);
    end
    // JALR base is unforwarded even when a forward would apply.
    regwriteW = 1'b1; rdW = 5'd1; ra1E = 5'd1; resultW = 32'h9000; #1;
    total++;
    if (jmp_fin_pcE !== 32'h1002) begin
      bad++;
      $display("FAIL jalr_nofwd: got %h want 00001002", jmp_fin_pcE);
    end
    jumpsrcE = 1'b0; pcE = 32'h2000; immE = 32'd5; #1;
    total++;
    if (jmp_fin_pcE !== 32'h2004) begin
      bad++;
      $display("FAIL jal: got %h want 00002004", jmp_fin_pcE);
    end
    memtoregE = 1'b1; rdE = 5'd4; ra1D = 5'd4; #1;
    total++;
    if ({stallF, stallD, flushD, flushE} !== 4'b1111) begin
      bad++;
      $display("FAIL jump_plus_lw: got %b want 1111", {stallF, stallD, flushD, flushE});
    end
  endtask

  task automatic test_reset_midrun();
    clear_inputs();
    memtoregE = 1'b1; rdE = 5'd3; ra1D = 5'd3; regwriteE = 1'b1; jumpE = 1'b1;
    rd1E = 32'h33; alusrcBE = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (aluoutM !== 32'd0 || rdM !== 5'd0 || regwriteM !== 1'b0 || memtoregM !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got aluoutM=%h rdM=%0d rw=%b mtr=%b want 0", aluoutM, rdM,
               regwriteM, memtoregM);
    end
    total++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++;
      $display("FAIL midrun_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    total++;
    if (stallF !== 1'b1 || controlChange !== 1'b1) begin
      bad++;
      $display("FAIL midrun_comb: got stallF=%b cc=%b want 1/1", stallF, controlChange);
    end
    @(negedge clk);
    clear_inputs();
    rd1E = 32'd2; alusrcBE = 2'b01; immE = 32'd3;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (aluoutM !== 32'd5) begin
      bad++;
      $display("FAIL release_add: got %h want 00000005", aluoutM);
    end
    clear_inputs();
    memtoregE = 1'b1; rdE = 5'd3; ra2D = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    clear_inputs();
    jumpE = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
`ifdef HAZARD_PERF_EN
    total++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_cnt: got %0d/%0d want 3/1", stall_cnt, flush_cnt);
    end
`else
    total++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++;
      $display("FAIL perf_tied: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_loaduse();
    test_branch();
    test_jump();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_hazard_core.md
Name: ex_hazard_core

Overview:
- Execute-stage compute core of the 5-stage RV32I pipeline.
- Combines operand forwarding, ALU, branch/jump target adders, branch resolution and the hazard unit (stall/flush/forward).
- Also contains the EX→MEM pipeline register, which supplies M-stage forwarding internally.
- Sits between the D→E register and data memory.

Parameters:
- CNT_W, 32, width of the optional hazard performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd1E, rd2E  in  32  register operands from the D→E register.
- pcE, immE  in  32  instruction PC and immediate.
- alucontrolE  in  4  ALU op.
- alusrcAE  in  1  srcA select: 0 = forwarded rs1, 1 = pcE.
- alusrcBE  in  2  srcB select: 00 = forwarded rs2, 01 = immE, 10/11 = 4.
- jumpsrcE  in  1  jump base select: 0 = pcE, 1 = rd1E (unforwarded).
- jumpE, branchE, inv_brE  in  1  control.
- regwriteE, memtoregE, memwriteE  in  1  control.
- ra1E, ra2E, rdE, ra1D, ra2D  in  5  register indices.
- resultW  in  32  writeback value.
- rdW  in  5  writeback destination.
- regwriteW  in  1  writeback enable.
- pcsrcE  out  1  branch taken.
- pcbranchE, jmp_fin_pcE  out  32  branch and jump targets.
- controlChange  out  1  pcsrcE | jumpE.
- stallF, stallD, flushD, flushE  out  1  hazard controls.
- forwardAE, forwardBE  out  2  forward selects.
- aluoutM, writedataM  out  32  registered M-stage values.
- rdM  out  5  registered M-stage destination.
- regwriteM, memtoregM, memwriteM  out  1  registered M-stage controls.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (optional feature).

Behaviour:
- Forwarding, per source X∈{A,B} with index raXE:
  - forwardXE=10 if regwriteM & rdM!=0 & raXE==rdM.
  - else 01 if regwriteW & rdW!=0 & raXE==rdW.
  - else 00.
  - M takes priority over W.
- Forwarded operands:
  - 00 → rdXE, 01 → resultW, 1x → aluoutM.
  - writedataE = forwarded rs2.
- ALU codes (b shift amount = b[4:0]):
  - 0000 add, 1000 sub, 0001 sll, 0010 slt (signed), 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1001 pass b.
  - All other codes → 0.
  - iszero = (aluout==0).
- Branch resolution:
  - pcsrcE = branchE & (iszero ^ inv_brE).
  - pcbranchE = pcE + immE, mod 2^32.
- Jump target:
  - jmp_fin_pcE = ((jumpsrcE ? rd1E : pcE) + immE) & ~1.
- Hazards (all combinational, same cycle):
  - lwstall = memtoregE & rdE!=0 & (rdE==ra1D | rdE==ra2D).
  - stallF = stallD = lwstall.
  - flushD = controlChange.
  - flushE = lwstall | controlChange.
  - lwstall and controlChange together: both apply; the flush wins on the D stage.
- EX→MEM register:
  - On each rising clk, captures aluout, writedataE, rdE, regwriteE, memtoregE, memwriteE into the *M outputs.
  - Never stalled or flushed (an E flush upstream already delivers a bubble).
- Reset: while reset=0, all registered outputs and counters = 0 asynchronously; combinational outputs still follow their inputs.
- Release: the first capture happens on the first rising edge after reset deasserts.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments each clock with lwstall=1.
  - flush_cnt increments each clock with controlChange=1.
  - Both wrap at 2^CNT_W and are cleared by reset.
- Undefined: counters not built; stall_cnt and flush_cnt tied to 0. All other behaviour identical.

Test Plan:
- ALU sweep, e.g. a=0x80000000, b=1:
  - add=0x80000001, sub=0x7FFFFFFF, slt=1, sltu=0, sra by 1=0xC0000000, srl by 1=0x40000000.
  - code 1010 → 0, iszero=1.
- Forward priority: regwriteM=1, rdM=5, aluoutM=7; regwriteW=1, rdW=5, resultW=9; ra1E=5 → forwardAE=10, srcA=7. With ra1E=0 → forwardAE=00.
- Load-use stall: memtoregE=1, rdE=3, ra2D=3 → stallF=stallD=flushE=1, flushD=0. With rdE=0 → all 0.
- Branch: branchE=1, inv_brE=1, sub with a=5, b=3 → pcsrcE=1, controlChange=1, flushD=flushE=1, pcbranchE=pcE+immE.
- Jump (JALR): jumpE=1, jumpsrcE=1, rd1E=0x1001, immE=2 → jmp_fin_pcE=0x1002, controlChange=1.
- Reset mid-run: assert reset=0 between clock edges → aluoutM, rdM, regwriteM and counters read 0 immediately. After release, one clock with add 2+3 → aluoutM=5. With HAZARD_PERF_EN and three lwstall cycles → stall_cnt=3.
